execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 167 ++++++++++++++++
 tb/tb_execute_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Decode/execute and execute/memory pipeline registers of the 16-bit CPU,
// with the operand-forwarding muxes and the ALU between them.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] nop_mux_output_in,
  input  logic [15:0] srcA_in,
  input  logic [15:0] srcB_in,
  input  logic [3:0]  rs1_decode,
  input  logic [3:0]  rs2_decode,
  input  logic [3:0]  rd_decode,
  input  logic [2:0]  select_forward_mux_A,
  input  logic [2:0]  select_forward_mux_B,
  input  logic [15:0] writeback_data,
  output logic        wre_execute,
  output logic        write_memory_enable_execute,
  output logic [1:0]  select_writeback_data_mux_execute,
  output logic [3:0]  aluOp_execute,
  output logic [15:0] srcA_execute,
  output logic [15:0] srcB_execute,
  output logic [3:0]  rs1_execute,
  output logic [3:0]  rs2_execute,
  output logic [3:0]  rd_execute,
  output logic [15:0] alu_result_execute,
  output logic        wre_memory,
  output logic        write_memory_enable_memory,
  output logic [1:0]  select_writeback_data_mux_memory,
  output logic [15:0] alu_result_memory,
  output logic [15:0] srcA_memory,
  output logic [15:0] srcB_memory,
  output logic [3:0]  rd_memory
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_MUL   = 4'd8,
    ALU_PASSB = 4'd9,
    ALU_PASSA = 4'd10,
    ALU_SLT   = 4'd11
  } alu_op_e;

  // Decode/execute register
  logic        r_wre_ex;
  logic        r_wme_ex;
  logic [1:0]  r_wbsel_ex;
  logic [3:0]  r_aluop_ex;
  logic [15:0] r_srcA_ex;
  logic [15:0] r_srcB_ex;
  logic [3:0]  r_rs1_ex;
  logic [3:0]  r_rs2_ex;
  logic [3:0]  r_rd_ex;

  // Execute/memory register
  logic        r_wre_mem;
  logic        r_wme_mem;
  logic [1:0]  r_wbsel_mem;
  logic [15:0] r_alu_mem;
  logic [15:0] r_srcA_mem;
  logic [15:0] r_srcB_mem;
  logic [3:0]  r_rd_mem;

  logic [15:0] w_opA;
  logic [15:0] w_opB;
  logic [15:0] w_alu;
  logic        w_unused_ctrl_hi;

  assign w_unused_ctrl_hi = ^nop_mux_output_in[15:8];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wre_ex    <= 1'b0;
      r_wme_ex    <= 1'b0;
      r_wbsel_ex  <= '0;
      r_aluop_ex  <= '0;
      r_srcA_ex   <= '0;
      r_srcB_ex   <= '0;
      r_rs1_ex    <= '0;
      r_rs2_ex    <= '0;
      r_rd_ex     <= '0;
      r_wre_mem   <= 1'b0;
      r_wme_mem   <= 1'b0;
      r_wbsel_mem <= '0;
      r_alu_mem   <= '0;
      r_srcA_mem  <= '0;
      r_srcB_mem  <= '0;
      r_rd_mem    <= '0;
    end else begin
      r_wre_ex    <= nop_mux_output_in[0];
      r_wme_ex    <= nop_mux_output_in[1];
      r_wbsel_ex  <= nop_mux_output_in[3:2];
      r_aluop_ex  <= nop_mux_output_in[7:4];
      r_srcA_ex   <= srcA_in;
      r_srcB_ex   <= srcB_in;
      r_rs1_ex    <= rs1_decode;
      r_rs2_ex    <= rs2_decode;
      r_rd_ex     <= rd_decode;
      r_wre_mem   <= r_wre_ex;
      r_wme_mem   <= r_wme_ex;
      r_wbsel_mem <= r_wbsel_ex;
      r_alu_mem   <= w_alu;
      r_srcA_mem  <= w_opA;
      r_srcB_mem  <= w_opB;
      r_rd_mem    <= r_rd_ex;
    end
  end

  // Forwarding: unused select codes fall back to the latched operand
  always_comb begin
    w_opA = r_srcA_ex;
    case (select_forward_mux_A)
      3'd1:    w_opA = writeback_data;
      3'd2:    w_opA = r_alu_mem;
      default: w_opA = r_srcA_ex;
    endcase
    w_opB = r_srcB_ex;
    case (select_forward_mux_B)
      3'd1:    w_opB = writeback_data;
      3'd2:    w_opB = r_alu_mem;
      default: w_opB = r_srcB_ex;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (alu_op_e'(r_aluop_ex))
      ALU_ADD:   w_alu = w_opA + w_opB;
      ALU_SUB:   w_alu = w_opA - w_opB;
      ALU_AND:   w_alu = w_opA & w_opB;
      ALU_OR:    w_alu = w_opA | w_opB;
      ALU_XOR:   w_alu = w_opA ^ w_opB;
      ALU_SLL:   w_alu = w_opA << w_opB[3:0];
      ALU_SRL:   w_alu = w_opA >> w_opB[3:0];
      ALU_SRA:   w_alu = $signed(w_opA) >>> w_opB[3:0];
      ALU_MUL:   w_alu = w_opA * w_opB;
      ALU_PASSB: w_alu = w_opB;
      ALU_PASSA: w_alu = w_opA;
      ALU_SLT:   w_alu = {15'd0, $signed(w_opA) < $signed(w_opB)};
      default:   w_alu = '0;
    endcase
  end

  assign wre_execute                       = r_wre_ex;
  assign write_memory_enable_execute       = r_wme_ex;
  assign select_writeback_data_mux_execute = r_wbsel_ex;
  assign aluOp_execute                     = r_aluop_ex;
  assign srcA_execute                      = r_srcA_ex;
  assign srcB_execute                      = r_srcB_ex;
  assign rs1_execute                       = r_rs1_ex;
  assign rs2_execute                       = r_rs2_ex;
  assign rd_execute                        = r_rd_ex;
  assign alu_result_execute                = w_alu;
  assign wre_memory                        = r_wre_mem;
  assign write_memory_enable_memory        = r_wme_mem;
  assign select_writeback_data_mux_memory  = r_wbsel_mem;
  assign alu_result_memory                 = r_alu_mem;
  assign srcA_memory                       = r_srcA_mem;
  assign srcB_memory                       = r_srcB_mem;
  assign rd_memory                         = r_rd_mem;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [15:0] nop_mux_output_in;
  logic [15:0] srcA_in;
  logic [15:0] srcB_in;
  logic [3:0]  rs1_decode;
  logic [3:0]  rs2_decode;
  logic [3:0]  rd_decode;
  logic [2:0]  select_forward_mux_A;
  logic [2:0]  select_forward_mux_B;
  logic [15:0] writeback_data;
  logic        wre_execute;
  logic        write_memory_enable_execute;
  logic [1:0]  select_writeback_data_mux_execute;
  logic [3:0]  aluOp_execute;
  logic [15:0] srcA_execute;
  logic [15:0] srcB_execute;
  logic [3:0]  rs1_execute;
  logic [3:0]  rs2_execute;
  logic [3:0]  rd_execute;
  logic [15:0] alu_result_execute;
  logic        wre_memory;
  logic        write_memory_enable_memory;
  logic [1:0]  select_writeback_data_mux_memory;
  logic [15:0] alu_result_memory;
  logic [15:0] srcA_memory;
  logic [15:0] srcB_memory;
  logic [3:0]  rd_memory;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk                               (clk),
    .reset                             (reset),
    .nop_mux_output_in                 (nop_mux_output_in),
    .srcA_in                           (srcA_in),
    .srcB_in                           (srcB_in),
    .rs1_decode                        (rs1_decode),
    .rs2_decode                        (rs2_decode),
    .rd_decode                         (rd_decode),
    .select_forward_mux_A              (select_forward_mux_A),
    .select_forward_mux_B              (select_forward_mux_B),
    .writeback_data                    (writeback_data),
    .wre_execute                       (wre_execute),
    .write_memory_enable_execute       (write_memory_enable_execute),
    .select_writeback_data_mux_execute (select_writeback_data_mux_execute),
    .aluOp_execute                     (aluOp_execute),
    .srcA_execute                      (srcA_execute),
    .srcB_execute                      (srcB_execute),
    .rs1_execute                       (rs1_execute),
    .rs2_execute                       (rs2_execute),
    .rd_execute                        (rd_execute),
    .alu_result_execute                (alu_result_execute),
    .wre_memory                        (wre_memory),
    .write_memory_enable_memory        (write_memory_enable_memory),
    .select_writeback_data_mux_memory  (select_writeback_data_mux_memory),
    .alu_result_memory                 (alu_result_memory),
    .srcA_memory                       (srcA_memory),
    .srcB_memory                       (srcB_memory),
    .rd_memory                         (rd_memory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd);
    nop_mux_output_in = ctrl;
    srcA_in           = a;
    srcB_in           = b;
    rd_decode         = rd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(16'hFFFF, 16'hA5A5, 16'h5A5A, 4'hF);
    rs1_decode = 4'h7;
    rs2_decode = 4'h9;
    select_forward_mux_A = 3'd0;
    select_forward_mux_B = 3'd0;
    writeback_data = 16'h1357;
    step();
    step();
    checks++;
    if ({wre_execute, write_memory_enable_execute, select_writeback_data_mux_execute,
         aluOp_execute} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl_ex: got %h want 00", {wre_execute, write_memory_enable_execute,
               select_writeback_data_mux_execute, aluOp_execute});
    end
    checks++;
    if ({srcA_execute, srcB_execute, rs1_execute, rs2_execute, rd_execute} !== 44'h0) begin
      errors++;
      $display("FAIL reset_data_ex: got %h want 0",
               {srcA_execute, srcB_execute, rs1_execute, rs2_execute, rd_execute});
    end
    checks++;
    if ({wre_memory, write_memory_enable_memory, select_writeback_data_mux_memory,
         alu_result_memory, srcA_memory, srcB_memory, rd_memory} !== 56'h0) begin
      errors++;
      $display("FAIL reset_mem: got %h want 0", {wre_memory, write_memory_enable_memory,
               select_writeback_data_mux_memory, alu_result_memory, srcA_memory, srcB_memory,
               rd_memory});
    end
    checks++;
    if (alu_result_execute !== 16'h0000) begin
      errors++;
      $display("FAIL reset_alu: got %h want 0000", alu_result_execute);
    end
  endtask

  task automatic test_add();
    reset = 1'b1;
    rs1_decode = 4'h1;
    rs2_decode = 4'h2;
    drive(16'h0001, 16'd5, 16'd7, 4'd3);
    step();
    checks++;
    if (alu_result_execute !== 16'd12 || wre_execute !== 1'b1 || rd_execute !== 4'd3 ||
        rs1_execute !== 4'h1 || rs2_execute !== 4'h2) begin
      errors++;
      $display("FAIL add_ex: alu=%0d wre=%b rd=%0d rs1=%0d rs2=%0d want 12 1 3 1 2",
               alu_result_execute, wre_execute, rd_execute, rs1_execute, rs2_execute);
    end
    drive(16'h0000, 16'd0, 16'd0, 4'd0);
    step();
    checks++;
    if (alu_result_memory !== 16'd12 || rd_memory !== 4'd3 || wre_memory !== 1'b1 ||
        srcA_memory !== 16'd5 || srcB_memory !== 16'd7) begin
      errors++;
      $display("FAIL add_mem: alu=%0d rd=%0d wre=%b a=%0d b=%0d want 12 3 1 5 7",
               alu_result_memory, rd_memory, wre_memory, srcA_memory, srcB_memory);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 9, 10, 11, 11, 12, 13, 14, 15};
    logic [15:0] av  [18] = '{16'hFFFF, 16'h0000, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0003,
                              16'h8000, 16'h8000, 16'h4000, 16'h012C, 16'h1234, 16'h1234,
                              16'hFFFF, 16'h0001, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    logic [15:0] bv  [18] = '{16'h0002, 16'h0001, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h0014,
                              16'h0004, 16'h0004, 16'h0004, 16'h012C, 16'h5678, 16'h5678,
                              16'h0001, 16'hFFFF, 16'h5678, 16'h5678, 16'h5678, 16'h5678};
    logic [15:0] ev  [18] = '{16'h0001, 16'hFFFF, 16'h3030, 16'hFCFC, 16'hCCCC, 16'h0030,
                              16'h0800, 16'hF800, 16'h0400, 16'h5F90, 16'h5678, 16'h1234,
                              16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 18; i++) begin
      drive({8'h00, ops[i], 4'h0}, av[i], bv[i], 4'd1);
      step();
      checks++;
      if (alu_result_execute !== ev[i] || aluOp_execute !== ops[i]) begin
        errors++;
        $display("FAIL alu_op%0d: a=%h b=%h got %h (op %0d) want %h", ops[i], av[i], bv[i],
                 alu_result_execute, aluOp_execute, ev[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    select_forward_mux_A = 3'd0;
    select_forward_mux_B = 3'd0;
    drive(16'h0001, 16'd20, 16'd20, 4'd4);
    step();
    drive(16'h0001, 16'd1, 16'd2, 4'd5);
    step();
    select_forward_mux_A = 3'd2;
    #1;
    checks++;
    if (alu_result_memory !== 16'd40 || alu_result_execute !== 16'd42) begin
      errors++;
      $display("FAIL fwd_mem: mem=%0d ex=%0d want 40 42", alu_result_memory, alu_result_execute);
    end
    select_forward_mux_A = 3'd1;
    writeback_data = 16'd9;
    #1;
    checks++;
    if (alu_result_execute !== 16'd11) begin
      errors++;
      $display("FAIL fwd_wb: got %0d want 11", alu_result_execute);
    end
    select_forward_mux_A = 3'd5;
    #1;
    checks++;
    if (alu_result_execute !== 16'd3) begin
      errors++;
      $display("FAIL fwd_sel5: got %0d want 3", alu_result_execute);
    end
    select_forward_mux_A = 3'd0;
    select_forward_mux_B = 3'd2;
    #1;
    checks++;
    if (alu_result_execute !== 16'd41) begin
      errors++;
      $display("FAIL fwd_b_mem: got %0d want 41", alu_result_execute);
    end
    select_forward_mux_A = 3'd1;
    select_forward_mux_B = 3'd7;
    drive(16'h0000, 16'd0, 16'd0, 4'd0);
    step();
    checks++;
    if (srcA_memory !== 16'd9 || srcB_memory !== 16'd2 || alu_result_memory !== 16'd11 ||
        rd_memory !== 4'd5) begin
      errors++;
      $display("FAIL fwd_latch: a=%0d b=%0d alu=%0d rd=%0d want 9 2 11 5",
               srcA_memory, srcB_memory, alu_result_memory, rd_memory);
    end
    select_forward_mux_A = 3'd0;
    select_forward_mux_B = 3'd0;
  endtask

  task automatic test_bubble();
    drive(16'h0002, 16'h0100, 16'hBEEF, 4'd0);
    step();
    checks++;
    if (write_memory_enable_execute !== 1'b1 || wre_execute !== 1'b0) begin
      errors++;
      $display("FAIL store_ex: wme=%b wre=%b want 1 0", write_memory_enable_execute, wre_execute);
    end
    drive(16'h0000, 16'h1111, 16'h2222, 4'd6);
    step();
    checks++;
    if (write_memory_enable_memory !== 1'b1 || srcB_memory !== 16'hBEEF ||
        srcA_memory !== 16'h0100 || write_memory_enable_execute !== 1'b0) begin
      errors++;
      $display("FAIL store_mem: wme=%b addr=%h data=%h wme_ex=%b want 1 0100 beef 0",
               write_memory_enable_memory, srcA_memory, srcB_memory, write_memory_enable_execute);
    end
    drive(16'hFF0D, 16'd0, 16'd0, 4'd0);
    step();
    checks++;
    if (write_memory_enable_memory !== 1'b0 || wre_memory !== 1'b0 || rd_memory !== 4'd6 ||
        srcA_memory !== 16'h1111) begin
      errors++;
      $display("FAIL bubble_mem: wme=%b wre=%b rd=%0d a=%h want 0 0 6 1111",
               write_memory_enable_memory, wre_memory, rd_memory, srcA_memory);
    end
    checks++;
    if (wre_execute !== 1'b1 || write_memory_enable_execute !== 1'b0 ||
        select_writeback_data_mux_execute !== 2'd3 || aluOp_execute !== 4'd0) begin
      errors++;
      $display("FAIL ctrl_split: wre=%b wme=%b wbsel=%0d op=%0d want 1 0 3 0", wre_execute,
               write_memory_enable_execute, select_writeback_data_mux_execute, aluOp_execute);
    end
    drive(16'h0000, 16'd0, 16'd0, 4'd0);
    step();
    checks++;
    if (select_writeback_data_mux_memory !== 2'd3 || wre_memory !== 1'b1) begin
      errors++;
      $display("FAIL wbsel_mem: wbsel=%0d wre=%b want 3 1", select_writeback_data_mux_memory,
               wre_memory);
    end
  endtask

  task automatic test_reset_mid();
    drive(16'h0002, 16'd3, 16'd4, 4'd2);
    step();
    reset = 1'b0;
    drive(16'h0003, 16'd8, 16'd9, 4'd7);
    step();
    checks++;
    if (write_memory_enable_memory !== 1'b0 || alu_result_memory !== 16'h0000 ||
        srcA_memory !== 16'h0000 || srcB_memory !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_mem: wme=%b alu=%h a=%h b=%h want 0 0000 0000 0000",
               write_memory_enable_memory, alu_result_memory, srcA_memory, srcB_memory);
    end
    checks++;
    if (write_memory_enable_execute !== 1'b0 || wre_execute !== 1'b0 ||
        srcA_execute !== 16'h0000 || alu_result_execute !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_ex: wme=%b wre=%b a=%h alu=%h want 0 0 0000 0000",
               write_memory_enable_execute, wre_execute, srcA_execute, alu_result_execute);
    end
    reset = 1'b1;
    step();
    checks++;
    if (wre_execute !== 1'b1 || write_memory_enable_execute !== 1'b1 ||
        alu_result_execute !== 16'd17) begin
      errors++;
      $display("FAIL reset_release: wre=%b wme=%b alu=%0d want 1 1 17", wre_execute,
               write_memory_enable_execute, alu_result_execute);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_forwarding();
    test_bubble();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
